// File: rtl/z80_pkg.sv
// -----------------------------------------------------------------------------
// z80_pkg
// Shared definitions for the Z80 boot-loader path.
//   state_t     : loader FSM states. The header states follow the on-wire field
//                 order: MAGIC, addr_lo, addr_hi, len_lo, len_hi, data..., chk.
//   MAGIC_BYTE  : default frame start byte.
//   in_frame()  : true while a frame is being received (busy / timeout window).
// -----------------------------------------------------------------------------
package z80_pkg;

  typedef enum logic [3:0] {
    ST_WAIT_MAGIC,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] MAGIC_BYTE = 8'hA5;

  function automatic logic in_frame(input state_t s);
    return (s == ST_ADDR_LO) || (s == ST_ADDR_HI) || (s == ST_LEN_LO) ||
           (s == ST_LEN_HI)  || (s == ST_DATA)    || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// -----------------------------------------------------------------------------
// loader_timeout
// Inter-byte watchdog. Reloaded on every clear, counts down while enabled and
// flags expire_o once CYCLES enabled cycles have elapsed since the last clear.
// CYCLES = 0 disables the watchdog (expire_o stays low).
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   clr_i    : reload the counter (an accepted byte)
//   en_i     : count this cycle (frame in progress)
//   expire_o : limit reached this cycle
// -----------------------------------------------------------------------------
module loader_timeout #(
  parameter int unsigned CYCLES = 27000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (CYCLES != 0) && en_i && (cnt_q == '0);

endmodule

// File: rtl/ram_loader.sv
// -----------------------------------------------------------------------------
// ram_loader
// Serial boot loader: parses frames  MAGIC, addr_lo, addr_hi, len_lo, len_hi,
// data[len], chk  from a valid/ready byte stream and writes the data bytes into
// a single-port block RAM. The Z80 is held in reset until a frame whose data
// bytes plus chk sum to 0 (mod 256) has been completely written.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   rx_data/rx_valid  : input byte stream
//   rx_ready          : byte accepted when rx_valid & rx_ready
//   ce, wre, ad, din  : RAM write strobe (one cycle), write enable, address, data
//   busy              : frame in progress
//   done              : load succeeded (sticky until reset)
//   error             : last frame failed (checksum or timeout)
//   cpu_reset         : Z80 reset, high until done
// -----------------------------------------------------------------------------
module ram_loader
  import z80_pkg::*;
#(
  parameter int          ADDR_W      = 11,
  parameter logic [7:0]  MAGIC       = MAGIC_BYTE,
  parameter int unsigned TIMEOUT_CYC = 27000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ce,
  output logic              wre,
  output logic [ADDR_W-1:0] ad,
  output logic [7:0]        din,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_reset
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;   // next RAM write address
  logic [15:0]         len_q, len_d;     // data bytes still to come
  logic [7:0]          lo_q, lo_d;       // low byte of addr/len while waiting for high byte
  logic [7:0]          sum_q, sum_d;     // running sum of data bytes
  logic                ce_q, ce_d;
  logic [ADDR_W-1:0]   ad_q, ad_d;
  logic [7:0]          din_q, din_d;

  logic                accept;
  logic                expire;
  logic [7:0]          csum;
  logic [15:0]         field16;

  assign accept  = rx_valid && rx_ready;
  assign csum    = sum_q + rx_data;
  assign field16 = {rx_data, lo_q};

  loader_timeout #(
    .CYCLES (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i    (clk),
    .rst_i    (reset),
    .clr_i    (accept),
    .en_i     (in_frame(state_q)),
    .expire_o (expire)
  );

  // State and write-port registers (reset to the documented idle values).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT_MAGIC;
      ce_q    <= 1'b0;
      ad_q    <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      ce_q    <= ce_d;
      ad_q    <= ad_d;
      din_q   <= din_d;
    end
  end

  // Frame datapath registers; only meaningful once the header has loaded them.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    len_q  <= len_d;
    lo_q   <= lo_d;
    sum_q  <= sum_d;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    lo_d    = lo_q;
    sum_d   = sum_q;
    ce_d    = 1'b0;
    ad_d    = ad_q;
    din_d   = din_q;

    if (accept) begin
      unique case (state_q)
        ST_WAIT_MAGIC, ST_ERROR: begin
          // Non-MAGIC bytes are swallowed; MAGIC (re)starts a frame.
          if (rx_data == MAGIC) begin
            state_d = ST_ADDR_LO;
            sum_d   = '0;
          end
        end
        ST_ADDR_LO: begin
          lo_d    = rx_data;
          state_d = ST_ADDR_HI;
        end
        ST_ADDR_HI: begin
          addr_d  = ADDR_W'(field16);
          state_d = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          lo_d    = rx_data;
          state_d = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          len_d   = field16;
          state_d = (field16 == 16'd0) ? ST_CSUM : ST_DATA;
        end
        ST_DATA: begin
          ce_d   = 1'b1;
          ad_d   = addr_q;
          din_d  = rx_data;
          addr_d = addr_q + ADDR_W'(1);
          len_d  = len_q - 16'd1;
          sum_d  = csum;
          if (len_q == 16'd1) begin
            state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          state_d = (csum == 8'd0) ? ST_DONE : ST_ERROR;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else if (expire) begin
      // An accepted byte on the expiry cycle wins over the timeout.
      state_d = ST_ERROR;
    end
  end

  // Outputs.
  always_comb begin
    rx_ready  = (state_q != ST_DONE);
    busy      = in_frame(state_q);
    done      = (state_q == ST_DONE);
    error     = (state_q == ST_ERROR);
    cpu_reset = (state_q != ST_DONE);
    ce        = ce_q;
    wre       = ce_q;
    ad        = ad_q;
    din       = din_q;
  end

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

  localparam int AW  = 11;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          ce;
  logic          wre;
  logic [AW-1:0] ad;
  logic [7:0]    din;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_reset;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t wq[$];     // writes observed on the RAM port
  wr_t exp_q[$];  // writes the model expects
  int  wre_err = 0;

  ram_loader #(
    .ADDR_W      (AW),
    .MAGIC       (8'hA5),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .ce        (ce),
    .wre       (wre),
    .ad        (ad),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpu_reset (cpu_reset)
  );

  always #5 clk = ~clk;

  // Every cycle with ce high is one RAM write.
  always @(negedge clk) begin
    if (ce === 1'b1) wq.push_back(wr_t'{a: ad, d: din});
    if (wre !== ce) wre_err++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] good_chk(input logic [7:0] d[$]);
    int s = 0;
    foreach (d[i]) s += d[i];
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic expect_writes(input logic [15:0] a, input logic [7:0] d[$]);
    exp_q.delete();
    foreach (d[i]) exp_q.push_back(wr_t'{a: AW'((int'(a) + i) % (1 << AW)), d: d[i]});
  endtask

  // ---------------- stimulus ----------------
  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [7:0] d[$],
                            input logic [7:0] chk, input int maxgap);
    send_byte(8'hA5, $urandom_range(0, maxgap));
    send_byte(a[7:0], $urandom_range(0, maxgap));
    send_byte(a[15:8], $urandom_range(0, maxgap));
    send_byte(8'(d.size()), $urandom_range(0, maxgap));
    send_byte(8'(d.size() >> 8), $urandom_range(0, maxgap));
    foreach (d[i]) send_byte(d[i], $urandom_range(0, maxgap));
    send_byte(chk, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++; if (ce !== 1'b0)        begin bad++; $display("FAIL reset_ce got=%b exp=0", ce); end
    total++; if (wre !== 1'b0)       begin bad++; $display("FAIL reset_wre got=%b exp=0", wre); end
    total++; if (ad !== '0)          begin bad++; $display("FAIL reset_ad got=%h exp=0", ad); end
    total++; if (din !== 8'h00)      begin bad++; $display("FAIL reset_din got=%h exp=0", din); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (error !== 1'b0)     begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset); end
    total++; if (rx_ready !== 1'b1)  begin bad++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] d[$];
    do_reset();
    d = '{8'h11, 8'h22, 8'h33};
    expect_writes(16'h0100, d);
    send_frame(16'h0100, d, 8'h9A, 0);
    total++; if (wq.size() != exp_q.size()) begin bad++; $display("FAIL basic_wcount got=%0d exp=%0d", wq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      total++; if (wq[i] !== exp_q[i]) begin bad++; $display("FAIL basic_wr%0d got=%h/%h exp=%h/%h", i, wq[i].a, wq[i].d, exp_q[i].a, exp_q[i].d); end
    end
    total++; if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL basic_status got done=%b cpu_reset=%b error=%b busy=%b exp 1 0 0 0", done, cpu_reset, error, busy); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_done got=%b exp=0", rx_ready); end
    // DONE is terminal: offered bytes are not taken and nothing is written.
    rx_data = 8'hA5; rx_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1; rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (wq.size() != 3 || done !== 1'b1) begin bad++; $display("FAIL basic_terminal got writes=%0d done=%b exp 3 1", wq.size(), done); end
  endtask

  task automatic test_bad_chk();
    logic [7:0] d[$];
    do_reset();
    d = '{8'h11, 8'h22, 8'h33};
    expect_writes(16'h0100, d);
    send_frame(16'h0100, d, 8'h9B, 1);
    total++; if (wq.size() != 3) begin bad++; $display("FAIL badchk_wcount got=%0d exp=3", wq.size()); end
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      total++; if (wq[i] !== exp_q[i]) begin bad++; $display("FAIL badchk_wr%0d got=%h/%h exp=%h/%h", i, wq[i].a, wq[i].d, exp_q[i].a, exp_q[i].d); end
    end
    total++; if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL badchk_status got error=%b cpu_reset=%b done=%b busy=%b exp 1 1 0 0", error, cpu_reset, done, busy); end
    wq.delete();
    send_frame(16'h0100, d, 8'h9A, 0);
    total++; if (wq.size() != 3 || done !== 1'b1 || error !== 1'b0 || cpu_reset !== 1'b0)
      begin bad++; $display("FAIL badchk_retry got writes=%0d done=%b error=%b cpu_reset=%b exp 3 1 0 0", wq.size(), done, error, cpu_reset); end
  endtask

  task automatic test_garbage_trunc();
    logic [7:0] d[$];
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 1);
    send_byte(8'h5A, 0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL garbage_busy got=%b exp=0", busy); end
    d = '{8'h7E};
    send_frame(16'h07FF, d, 8'h82, 0);
    total++; if (wq.size() != 1) begin bad++; $display("FAIL garbage_wcount got=%0d exp=1", wq.size()); end
    else begin
      total++; if (wq[0] !== wr_t'{a: 11'h7FF, d: 8'h7E}) begin bad++; $display("FAIL garbage_wr got=%h/%h exp=7ff/7e", wq[0].a, wq[0].d); end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL garbage_done got=%b exp=1", done); end
  endtask

  task automatic test_wrap();
    logic [7:0] d[$];
    do_reset();
    d = '{8'($urandom), 8'($urandom)};
    expect_writes(16'h07FF, d);
    send_frame(16'h07FF, d, good_chk(d), 0);
    total++; if (wq.size() != 2) begin bad++; $display("FAIL wrap_wcount got=%0d exp=2", wq.size()); end
    for (int i = 0; i < 2 && i < wq.size(); i++) begin
      total++; if (wq[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_wr%0d got=%h/%h exp=%h/%h", i, wq[i].a, wq[i].d, exp_q[i].a, exp_q[i].d); end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b exp=1", done); end
  endtask

  task automatic test_zero_len();
    logic [7:0] d[$];
    do_reset();
    d.delete();
    send_frame(16'h0000, d, 8'h00, 0);
    total++; if (wq.size() != 0) begin bad++; $display("FAIL zero_wcount got=%0d exp=0", wq.size()); end
    total++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin bad++; $display("FAIL zero_done got done=%b cpu_reset=%b exp 1 0", done, cpu_reset); end
  endtask

  task automatic test_random();
    logic [7:0]  d[$];
    logic [15:0] a;
    logic [7:0]  chk, g;
    bit          good;
    int          n;
    do_reset();
    for (int f = 0; f < 14; f++) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, $urandom_range(0, 2));
      end
      a = 16'($urandom);
      d.delete();
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) d.push_back(8'($urandom));
      good = ($urandom_range(0, 3) != 0);
      chk  = good ? good_chk(d) : (good_chk(d) ^ 8'($urandom_range(1, 255)));
      expect_writes(a, d);
      send_frame(a, d, chk, 3);
      total++; if (wq.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_wcount got=%0d exp=%0d", f, wq.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
        total++; if (wq[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_wr%0d got=%h/%h exp=%h/%h", f, i, wq[i].a, wq[i].d, exp_q[i].a, exp_q[i].d); end
      end
      total++; if (done !== good || error !== !good || cpu_reset !== !good || busy !== 1'b0)
        begin bad++; $display("FAIL rnd%0d_status got done=%b error=%b cpu_reset=%b busy=%b exp good=%b", f, done, error, cpu_reset, busy, good); end
      if (good) do_reset();
      else wq.delete();
    end
  endtask

  task automatic test_timeout();
    // Stall after two data bytes: error appears after the inter-byte limit.
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h04, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    repeat (TMO) begin @(posedge clk); #1; end
    total++; if (error !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_early got error=%b busy=%b exp 0 1", error, busy); end
    @(posedge clk); #1;
    total++; if (error !== 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1)
      begin bad++; $display("FAIL tmo_expire got error=%b busy=%b cpu_reset=%b exp 1 0 1", error, busy, cpu_reset); end
    repeat (2) @(posedge clk); #1;
    total++; if (wq.size() != 2) begin bad++; $display("FAIL tmo_wcount got=%0d exp=2", wq.size()); end

    // A byte landing on the expiry cycle is taken and the frame continues.
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h04, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    repeat (TMO) begin @(posedge clk); #1; end
    send_byte(8'h33, 0);
    total++; if (error !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_race got error=%b busy=%b exp 0 1", error, busy); end
    send_byte(8'h44, 0);
    send_byte(8'h56, 0);
    repeat (2) @(posedge clk); #1;
    total++; if (done !== 1'b1 || wq.size() != 4) begin bad++; $display("FAIL tmo_race_done got done=%b writes=%0d exp 1 4", done, wq.size()); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d[$];
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h04, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    // Reset coincides with a data byte: that write must never appear.
    rx_data = 8'h33; rx_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; reset = 1'b0;
    total++; if (ce !== 1'b0 || cpu_reset !== 1'b1 || busy !== 1'b0 || ad !== '0)
      begin bad++; $display("FAIL rstmid_state got ce=%b cpu_reset=%b busy=%b ad=%h exp 0 1 0 0", ce, cpu_reset, busy, ad); end
    repeat (2) @(posedge clk); #1;
    total++; if (wq.size() != 2) begin bad++; $display("FAIL rstmid_wcount got=%0d exp=2", wq.size()); end
    wq.delete();
    d.delete();
    send_frame(16'h0000, d, 8'h00, 0);
    total++; if (done !== 1'b1 || wq.size() != 0) begin bad++; $display("FAIL rstmid_restart got done=%b writes=%0d exp 1 0", done, wq.size()); end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_bad_chk();
    test_garbage_trunc();
    test_wrap();
    test_zero_len();
    test_random();
    test_timeout();
    test_reset_mid();
    total++; if (wre_err != 0) begin bad++; $display("FAIL wre_eq_ce got=%0d cycles differing exp=0", wre_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
